// File: rtl/descriptor_pkg.sv
// Shared constants, done codes and FSM state encoding for the descriptor fetch master.
package descriptor_pkg;

  localparam int OWN_BIT    = 31;
  localparam int EOP_BIT    = 30;
  localparam int LEN_W      = 16;
  localparam int DESC_WORDS = 3;

  // The control byte is word1[31:24]; these index into that byte.
  localparam int CTRL_OWN = OWN_BIT - 24;
  localparam int CTRL_EOP = EOP_BIT - 24;

  localparam logic [1:0] DONE_EOP       = 2'b00;
  localparam logic [1:0] DONE_NOT_OWNED = 2'b01;
  localparam logic [1:0] DONE_NULL_NEXT = 2'b10;
  localparam logic [1:0] DONE_LIMIT     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_PRESENT,
    ST_WB,
    ST_NEXT,
    ST_FINISH
  } state_t;

  function automatic logic [31:0] wb_data(input logic [7:0] ctrl);
    return {1'b0, ctrl[6:0], 24'h0};
  endfunction

endpackage

// File: rtl/descriptor_fetch_master_if.sv
// Avalon-MM master bus plus the descriptor valid/ready stream toward the consumer.
interface descriptor_fetch_master_if #(
  parameter int ADDR_W = 10
) ();

  logic [ADDR_W-1:0]                m_address;
  logic                             m_read;
  logic                             m_write;
  logic [3:0]                       m_byteenable;
  logic [31:0]                      m_writedata;
  logic [31:0]                      m_readdata;
  logic                             m_readdatavalid;
  logic                             m_waitrequest;
  logic                             desc_valid;
  logic                             desc_ready;
  logic [31:0]                      desc_buf_addr;
  logic [descriptor_pkg::LEN_W-1:0] desc_length;
  logic                             desc_eop;

  modport master (
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_readdata, m_readdatavalid, m_waitrequest,
    output desc_valid, desc_buf_addr, desc_length, desc_eop,
    input  desc_ready
  );

  modport slave (
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_readdata, m_readdatavalid, m_waitrequest,
    input  desc_valid, desc_buf_addr, desc_length, desc_eop,
    output desc_ready
  );

endinterface

// File: rtl/descriptor_fetch_master.sv
// Walks a linked descriptor chain: read 3 words, hand off, clear OWN, follow next.
module descriptor_fetch_master
  import descriptor_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_CHAIN = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_code,
  output logic [8:0]        desc_count,
  descriptor_fetch_master_if.master bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        w_finish_code;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_idx;
  logic [31:0]       r_buf_addr;
  logic [7:0]        r_ctrl;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_next;
  logic [8:0]        r_count;
  logic [1:0]        r_done_code;
  logic              w_last_word;

  assign w_last_word = (r_idx == 2'(DESC_WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_finish_code = r_done_code;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_RD_REQ;
      ST_RD_REQ:  if (!bus.m_waitrequest) w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (bus.m_readdatavalid) w_state_next = w_last_word ? ST_CHECK : ST_RD_REQ;
      ST_CHECK: begin
        if (!r_ctrl[CTRL_OWN]) begin
          w_state_next  = ST_FINISH;
          w_finish_code = DONE_NOT_OWNED;
        end else if (abort) begin
          w_state_next  = ST_FINISH;
          w_finish_code = DONE_LIMIT;
        end else begin
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: if (bus.desc_ready) w_state_next = ST_WB;
      ST_WB:      if (!bus.m_waitrequest) w_state_next = ST_NEXT;
      ST_NEXT: begin
        w_state_next = ST_FINISH;
        if (r_ctrl[CTRL_EOP])                         w_finish_code = DONE_EOP;
        else if (r_next == '0)                        w_finish_code = DONE_NULL_NEXT;
        else if (r_count == 9'(MAX_CHAIN) || abort)   w_finish_code = DONE_LIMIT;
        else                                          w_state_next  = ST_RD_REQ;
      end
      ST_FINISH:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base      <= '0;
      r_idx       <= '0;
      r_buf_addr  <= '0;
      r_ctrl      <= '0;
      r_len       <= '0;
      r_next      <= '0;
      r_count     <= '0;
      r_done_code <= DONE_EOP;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_base      <= start_addr;
          r_idx       <= '0;
          r_count     <= '0;
          r_done_code <= DONE_EOP;
        end
        ST_RD_WAIT: if (bus.m_readdatavalid) begin
          case (r_idx)
            2'd0: r_buf_addr <= bus.m_readdata;
            2'd1: begin
              r_ctrl <= bus.m_readdata[31:24];
              r_len  <= bus.m_readdata[LEN_W-1:0];
            end
            default: r_next <= bus.m_readdata[ADDR_W-1:0];
          endcase
          r_idx <= w_last_word ? 2'd0 : r_idx + 2'd1;
        end
        ST_PRESENT: if (bus.desc_ready) r_count <= r_count + 9'd1;
        ST_NEXT: begin
          r_base <= r_next;
          r_idx  <= '0;
        end
        default: ;
      endcase
      if (w_state_next == ST_FINISH && r_state != ST_FINISH)
        r_done_code <= w_finish_code;
    end
  end

  // Bus outputs are decoded from state so they are idle-zero straight out of reset.
  always_comb begin
    bus.m_read       = (r_state == ST_RD_REQ);
    bus.m_write      = (r_state == ST_WB);
    bus.m_byteenable = (r_state == ST_WB) ? 4'b1000 : 4'b1111;
    bus.m_writedata  = (r_state == ST_WB) ? wb_data(r_ctrl) : 32'h0;
    case (r_state)
      ST_RD_REQ: bus.m_address = r_base + ADDR_W'(r_idx);
      ST_WB:     bus.m_address = r_base + ADDR_W'(1);
      default:   bus.m_address = '0;
    endcase
  end

  assign bus.desc_valid    = (r_state == ST_PRESENT);
  assign bus.desc_buf_addr = r_buf_addr;
  assign bus.desc_length   = r_len;
  assign bus.desc_eop      = r_ctrl[CTRL_EOP];
  assign busy              = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done              = (r_state == ST_FINISH);
  assign done_code         = r_done_code;
  assign desc_count        = r_count;

endmodule

// File: tb/tb_descriptor_fetch_master.sv
// Scoreboard bench: a behavioural Avalon memory slave and monitors check reads, writes, handoffs and done.
`timescale 1ns/1ps
module tb_descriptor_fetch_master;
  import descriptor_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int MAX_CHAIN = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              busy;
  logic              done;
  logic [1:0]        done_code;
  logic [8:0]        desc_count;

  descriptor_fetch_master_if #(.ADDR_W(ADDR_W)) bus ();

  descriptor_fetch_master #(.ADDR_W(ADDR_W), .MAX_CHAIN(MAX_CHAIN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .done_code  (done_code),
    .desc_count (desc_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [31:0] addr; logic [15:0] len; logic eop;} desc_exp_t;
  typedef struct packed {logic [ADDR_W-1:0] addr; logic [31:0] data;} wr_exp_t;
  typedef struct packed {logic [1:0] code; logic [8:0] count;} done_exp_t;

  logic [31:0]       mem [0:1023];
  desc_exp_t         desc_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  wr_exp_t           wr_q[$];
  done_exp_t         done_q[$];

  int  wait_mode = 0;   // 0 none, 1 random, 2 stall every write
  int  rd_lat    = 1;
  bit  rdy_stall = 0;
  bit  mem_wr_en = 1;

  logic              acc_rd, acc_wr;
  logic [ADDR_W-1:0] acc_rd_addr, acc_wr_addr;
  logic [31:0]       acc_wr_data;
  logic [3:0]        acc_wr_be;

  logic              prev_rd_stall = 0, prev_wr_stall = 0, prev_desc_stall = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_wdata, prev_buf;
  logic [15:0]       prev_len;
  logic              prev_eop;

  // Slave side driver: runs just after each rising edge.
  initial begin
    int        pend_cnt;
    int        rdy_cnt;
    logic [31:0] pend_data;
    pend_cnt = 0;
    rdy_cnt  = 0;
    pend_data = '0;
    bus.m_readdata      = '0;
    bus.m_readdatavalid = 1'b0;
    bus.m_waitrequest   = 1'b0;
    bus.desc_ready      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_readdatavalid = 1'b0;
      if (!reset_n) begin
        pend_cnt = 0;
      end else begin
        if (acc_rd) begin
          if (rd_lat <= 1) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = mem[acc_rd_addr];
          end else begin
            pend_cnt  = rd_lat - 1;
            pend_data = mem[acc_rd_addr];
          end
        end else if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = pend_data;
          end
        end
        if (acc_wr && mem_wr_en) begin
          for (int b = 0; b < 4; b++)
            if (acc_wr_be[b]) mem[acc_wr_addr][b*8 +: 8] = acc_wr_data[b*8 +: 8];
        end
      end
      case (wait_mode)
        1:       bus.m_waitrequest = ($urandom_range(0, 1) == 1);
        2:       bus.m_waitrequest = bus.m_write;
        default: bus.m_waitrequest = 1'b0;
      endcase
      if (bus.desc_valid) rdy_cnt++;
      else                rdy_cnt = 0;
      bus.desc_ready = rdy_stall ? (rdy_cnt > 5) : 1'b1;
    end
  end

  // Monitor: sample mid-cycle, each handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    acc_rd      = reset_n && bus.m_read && !bus.m_waitrequest;
    acc_rd_addr = bus.m_address;
    acc_wr      = reset_n && bus.m_write && !bus.m_waitrequest;
    acc_wr_addr = bus.m_address;
    acc_wr_data = bus.m_writedata;
    acc_wr_be   = bus.m_byteenable;
    if (!reset_n) begin
      prev_rd_stall   = 0;
      prev_wr_stall   = 0;
      prev_desc_stall = 0;
    end else begin
      checks++;
      if (bus.m_read && bus.m_write) begin
        errors++;
        $display("FAIL rw_overlap: m_read=%b m_write=%b, required not both high", bus.m_read, bus.m_write);
      end
      if (prev_rd_stall) begin
        checks++;
        if (!bus.m_read || bus.m_address != prev_addr) begin
          errors++;
          $display("FAIL rd_hold: read=%b addr=%h, required read=1 addr=%h", bus.m_read, bus.m_address, prev_addr);
        end
      end
      if (prev_wr_stall) begin
        checks++;
        if (!bus.m_write || bus.m_address != prev_addr || bus.m_writedata != prev_wdata || bus.m_byteenable != 4'b1000) begin
          errors++;
          $display("FAIL wr_hold: write=%b addr=%h data=%h be=%b, required write=1 addr=%h data=%h be=1000",
                   bus.m_write, bus.m_address, bus.m_writedata, bus.m_byteenable, prev_addr, prev_wdata);
        end
      end
      if (prev_desc_stall) begin
        checks++;
        if (!bus.desc_valid || bus.desc_buf_addr != prev_buf || bus.desc_length != prev_len || bus.desc_eop != prev_eop) begin
          errors++;
          $display("FAIL desc_hold: valid=%b addr=%h len=%h eop=%b, required valid=1 addr=%h len=%h eop=%b",
                   bus.desc_valid, bus.desc_buf_addr, bus.desc_length, bus.desc_eop, prev_buf, prev_len, prev_eop);
        end
      end
      if (acc_rd) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: got read at %h, required no read", bus.m_address);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = rd_q.pop_front();
          if (bus.m_address != ea || bus.m_byteenable != 4'b1111) begin
            errors++;
            $display("FAIL rd_addr: got addr=%h be=%b, required addr=%h be=1111", bus.m_address, bus.m_byteenable, ea);
          end
        end
      end
      if (acc_wr) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr: got write addr=%h data=%h, required no write", bus.m_address, bus.m_writedata);
        end else begin
          wr_exp_t ew;
          ew = wr_q.pop_front();
          if (bus.m_address != ew.addr || bus.m_writedata != ew.data || bus.m_byteenable != 4'b1000) begin
            errors++;
            $display("FAIL wr: got addr=%h data=%h be=%b, required addr=%h data=%h be=1000",
                     bus.m_address, bus.m_writedata, bus.m_byteenable, ew.addr, ew.data);
          end
        end
      end
      if (bus.desc_valid && bus.desc_ready) begin
        checks++;
        if (desc_q.size() == 0) begin
          errors++;
          $display("FAIL desc: got handoff addr=%h, required no handoff", bus.desc_buf_addr);
        end else begin
          desc_exp_t ed;
          ed = desc_q.pop_front();
          if (bus.desc_buf_addr != ed.addr || bus.desc_length != ed.len || bus.desc_eop != ed.eop) begin
            errors++;
            $display("FAIL desc: got addr=%h len=%h eop=%b, required addr=%h len=%h eop=%b",
                     bus.desc_buf_addr, bus.desc_length, bus.desc_eop, ed.addr, ed.len, ed.eop);
          end else begin
            $display("handoff addr=%h len=%h eop=%b", bus.desc_buf_addr, bus.desc_length, bus.desc_eop);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done: got unexpected done code=%b", done_code);
        end else begin
          done_exp_t ex;
          ex = done_q.pop_front();
          if (done_code != ex.code || desc_count != ex.count || busy) begin
            errors++;
            $display("FAIL done: got code=%b count=%0d busy=%b, required code=%b count=%0d busy=0",
                     done_code, desc_count, busy, ex.code, ex.count);
          end else begin
            $display("done code=%b count=%0d", done_code, desc_count);
          end
        end
      end
      prev_rd_stall   = bus.m_read && bus.m_waitrequest;
      prev_wr_stall   = bus.m_write && bus.m_waitrequest;
      prev_desc_stall = bus.desc_valid && !bus.desc_ready;
      prev_addr       = bus.m_address;
      prev_wdata      = bus.m_writedata;
      prev_buf        = bus.desc_buf_addr;
      prev_len        = bus.desc_length;
      prev_eop        = bus.desc_eop;
    end
  end

  task automatic load(input logic [ADDR_W-1:0] b, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [ADDR_W-1:0] a;
    a = b;
    mem[a] = w0;
    a = a + 1'b1;
    mem[a] = w1;
    a = a + 1'b1;
    mem[a] = w2;
  endtask

  task automatic exp_reads(input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(a);
      a = a + 1'b1;
    end
  endtask

  task automatic exp_desc(input logic [ADDR_W-1:0] b, input logic [31:0] addr, input logic [15:0] len,
                          input logic eop, input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
    exp_reads(b);
    desc_q.push_back('{addr: addr, len: len, eop: eop});
    wr_q.push_back('{addr: wa, data: wd});
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    @(posedge clk);
    #2;
    start      = 1'b1;
    start_addr = a;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic flush_queues();
    rd_q.delete();
    wr_q.delete();
    desc_q.delete();
    done_q.delete();
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done within 4000 cycles, required done", name);
    end
    @(negedge clk);
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || desc_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got pending rd=%0d wr=%0d desc=%0d done=%0d, required all 0",
               name, rd_q.size(), wr_q.size(), desc_q.size(), done_q.size());
    end
    flush_queues();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (busy || done || done_code != 2'b00 || desc_count != 9'd0 || bus.m_read || bus.m_write ||
        bus.m_address != '0 || bus.m_byteenable != 4'b1111 || bus.m_writedata != 32'h0 ||
        bus.desc_valid || bus.desc_buf_addr != 32'h0 || bus.desc_length != 16'h0 || bus.desc_eop) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b code=%b cnt=%0d rd=%b wr=%b addr=%h be=%b wd=%h dv=%b ba=%h len=%h eop=%b, required all 0 with be=1111",
               name, busy, done, done_code, desc_count, bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable,
               bus.m_writedata, bus.desc_valid, bus.desc_buf_addr, bus.desc_length, bus.desc_eop);
    end
  endtask

  task automatic check_mem(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    checks++;
    if (mem[a] != exp) begin
      errors++;
      $display("FAIL %s: got mem[%h]=%h, required %h", name, a, mem[a], exp);
    end
  endtask

  task automatic load_chain3();
    load(10'h000, 32'h0000_1000, 32'h8000_0010, 32'h0000_0020);
    load(10'h020, 32'h0000_2000, 32'h8000_0020, 32'h0000_03FE);
    load(10'h3FE, 32'h0000_3000, 32'hC000_0030, 32'h0000_1000);
  endtask

  task automatic exp_chain3();
    exp_desc(10'h000, 32'h0000_1000, 16'h0010, 1'b0, 10'h001, 32'h0000_0000);
    exp_desc(10'h020, 32'h0000_2000, 16'h0020, 1'b0, 10'h021, 32'h0000_0000);
    exp_desc(10'h3FE, 32'h0000_3000, 16'h0030, 1'b1, 10'h3FF, 32'h4000_0000);
    done_q.push_back('{code: DONE_EOP, count: 9'd3});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Single descriptor, zero-wait slave.
    load(10'h010, 32'h0000_4000, 32'hC000_0100, 32'h0000_0000);
    exp_desc(10'h010, 32'h0000_4000, 16'h0100, 1'b1, 10'h011, 32'h4000_0000);
    done_q.push_back('{code: DONE_EOP, count: 9'd1});
    pulse_start(10'h010);
    wait_done("single");
    check_mem("single_wb", 10'h011, 32'h4000_0100);

    // Three-descriptor chain with address wrap; a start while busy must be ignored.
    load_chain3();
    exp_chain3();
    pulse_start(10'h000);
    repeat (4) @(posedge clk);
    pulse_start(10'h300);
    wait_done("chain");
    check_mem("chain_wb3", 10'h3FF, 32'h4000_0030);

    // Second descriptor not owned.
    load(10'h100, 32'h0000_5000, 32'h8000_0040, 32'h0000_0200);
    load(10'h200, 32'h0000_6000, 32'h4000_0050, 32'h0000_0000);
    exp_desc(10'h100, 32'h0000_5000, 16'h0040, 1'b0, 10'h101, 32'h0000_0000);
    exp_reads(10'h200);
    done_q.push_back('{code: DONE_NOT_OWNED, count: 9'd1});
    pulse_start(10'h100);
    wait_done("not_owned");
    check_mem("not_owned_untouched", 10'h201, 32'h4000_0050);

    // Same chain under random stalls, read latency 3 and a slow consumer.
    load_chain3();
    wait_mode = 1;
    rd_lat    = 3;
    rdy_stall = 1;
    exp_chain3();
    pulse_start(10'h000);
    wait_done("stall_chain");
    wait_mode = 0;
    rd_lat    = 1;
    rdy_stall = 0;

    // Self-looping descriptor stops at the chain limit; write-backs are not stored.
    load(10'h050, 32'h0000_7000, 32'h8000_0008, 32'h0000_0050);
    mem_wr_en = 0;
    for (int i = 0; i < MAX_CHAIN; i++)
      exp_desc(10'h050, 32'h0000_7000, 16'h0008, 1'b0, 10'h051, 32'h0000_0000);
    done_q.push_back('{code: DONE_LIMIT, count: 9'(MAX_CHAIN)});
    pulse_start(10'h050);
    wait_done("limit");
    mem_wr_en = 1;

    // Abort raised while the descriptor is presented.
    load(10'h080, 32'h0000_8000, 32'h8000_0011, 32'h0000_0090);
    exp_desc(10'h080, 32'h0000_8000, 16'h0011, 1'b0, 10'h081, 32'h0000_0000);
    done_q.push_back('{code: DONE_LIMIT, count: 9'd1});
    pulse_start(10'h080);
    begin
      bit seen_v;
      seen_v = 0;
      for (int i = 0; i < 200 && !seen_v; i++) begin
        @(negedge clk);
        if (bus.desc_valid) seen_v = 1;
      end
      checks++;
      if (!seen_v) begin
        errors++;
        $display("FAIL abort_valid_timeout: got no desc_valid, required desc_valid");
      end
      abort = 1'b1;
    end
    wait_done("abort");
    abort = 1'b0;

    // Reset while the write-back is stalled, then a normal restart.
    load(10'h0C0, 32'h0000_9000, 32'h8000_0012, 32'h0000_0000);
    exp_desc(10'h0C0, 32'h0000_9000, 16'h0012, 1'b0, 10'h0C1, 32'h0000_0000);
    wait_mode = 2;
    pulse_start(10'h0C0);
    begin
      bit seen_w;
      seen_w = 0;
      for (int i = 0; i < 200 && !seen_w; i++) begin
        @(negedge clk);
        if (bus.m_write) seen_w = 1;
      end
      checks++;
      if (!seen_w) begin
        errors++;
        $display("FAIL wb_stall_timeout: got no m_write, required m_write");
      end
    end
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_wb");
    flush_queues();
    wait_mode = 0;
    repeat (2) @(negedge clk);
    check_mem("reset_own_kept", 10'h0C1, 32'h8000_0012);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    exp_desc(10'h0C0, 32'h0000_9000, 16'h0012, 1'b0, 10'h0C1, 32'h0000_0000);
    done_q.push_back('{code: DONE_NULL_NEXT, count: 9'd1});
    pulse_start(10'h0C0);
    wait_done("after_reset");
    check_mem("after_reset_wb", 10'h0C1, 32'h0000_0012);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/descriptor_fetch_master.md
Name: descriptor_fetch_master

Overview:
- Avalon-MM master that walks a linked chain of descriptors held in the 1024x32 on-chip descriptor memory.
- For each descriptor it:
  - reads the descriptor words;
  - presents the decoded descriptor to a downstream consumer over a valid/ready handshake;
  - writes back the control byte with the OWN bit cleared;
  - follows the next pointer.
- Sits between the descriptor memory's slave port and the audio/DMA datapath.

Parameters:
- ADDR_W, 10: word-address width of the descriptor memory.
- MAX_CHAIN, 256: loop guard; maximum descriptors processed per start.

Ports:
- clk  in  1: system clock.
- reset_n  in  1: asynchronous active-low reset.
- start  in  1: one-cycle pulse; begin a chain at start_addr (ignored unless idle).
- start_addr  in  ADDR_W: word address of the first descriptor.
- abort  in  1: level; stop at the next safe point.
- busy  out  1: high from accepted start until done.
- done  out  1: one-cycle completion pulse.
- done_code  out  2: 00 EOP, 01 not-owned, 10 null-next, 11 limit/abort; held until next start.
- desc_count  out  9: descriptors handed off in the current/last chain.
- m_address  out  ADDR_W: Avalon word address.
- m_read  out  1: Avalon read request.
- m_write  out  1: Avalon write request.
- m_byteenable  out  4: Avalon byte enables.
- m_writedata  out  32: Avalon write data.
- m_readdata  in  32: Avalon read data.
- m_readdatavalid  in  1: read data valid.
- m_waitrequest  in  1: slave stall.
- desc_valid  out  1: descriptor available to the consumer.
- desc_ready  in  1: consumer accepts the descriptor.
- desc_buf_addr  out  32: descriptor word0.
- desc_length  out  16: word1[15:0].
- desc_eop  out  1: word1[30].

Behaviour:
- Descriptor layout (3 words at base B):
  - B+0 = buffer address.
  - B+1 = {OWN[31], EOP[30], rsvd[29:16], length[15:0]}.
  - B+2 = next pointer; bits [ADDR_W-1:0] used, 0 = null.
- Address arithmetic is modulo 2^ADDR_W; B+1 and B+2 wrap past 1023.
- Reset values: all outputs 0; state IDLE; m_byteenable 4'b1111.
- States:
  - IDLE: on start, latch start_addr as B, clear desc_count, busy=1, go to RD_REQ with word index 0.
  - RD_REQ: m_read=1, m_address=B+idx, byteenable 1111. Hold address and read stable while m_waitrequest=1. On accept go to RD_WAIT.
  - RD_WAIT: on m_readdatavalid, store word idx. If idx=2 go to CHECK, else idx+1 and return to RD_REQ. Only one outstanding read at a time. Any pipeline latency ≥1 is tolerated.
  - CHECK (1 cycle):
    - OWN=0: finish with code 01; no handoff, no write-back.
    - abort=1: finish with code 11.
    - Otherwise go to PRESENT.
  - PRESENT: desc_valid=1 with fields stable until desc_ready sampled high. Transfer occurs on the edge where desc_valid & desc_ready. Then desc_count+1 and go to WB.
  - WB: m_write=1, m_address=B+1, m_byteenable=4'b1000, m_writedata={1'b0, word1[30:24], 24'h0}. Hold while m_waitrequest. On accept go to NEXT.
  - NEXT (1 cycle), first match wins:
    - EOP → code 00.
    - next==0 → code 10.
    - desc_count==MAX_CHAIN or abort → code 11.
    - Otherwise B=next, idx=0, go to RD_REQ.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- An outstanding read or write is never abandoned; abort is evaluated only in CHECK and NEXT.
- m_read and m_write are never asserted together.
- start while busy is ignored.
- Async reset mid-transaction returns to IDLE immediately. The memory-side write is not completed and the descriptor is left with OWN=1.

Decomposition:
- Shared package descriptor_pkg:
  - OWN_BIT=31, EOP_BIT=30, LEN_W=16, DESC_WORDS=3.
  - Done-code constants.
  - State enum.
- No sub-module: a single FSM with word registers.

Test Plan:
- Single descriptor at 0x010: {0x0000_4000, 0xC000_0100, 0x0}, zero-wait slave, latency 1.
  - desc_valid shows addr 0x4000, length 0x100, eop=1.
  - After ready, write to 0x011 with be=1000, data 0x4000_0000.
  - done with code 00; desc_count=1.
- Chain 0x000→0x020→0x3FE with OWN=1 and EOP only on the last.
  - Third descriptor reads 0x3FE, 0x3FF, 0x000 (wrap).
  - Three handoffs, code 00.
- Second descriptor has OWN=0.
  - One handoff only, no write to the second descriptor, code 01.
- m_waitrequest randomly high, readdatavalid delayed 3 cycles, desc_ready held low 5 cycles.
  - Address, read and write held stable while stalled.
  - desc fields stable while valid.
  - Results identical to the zero-wait case.
- Self-loop descriptor (next=own address, EOP=0), MAX_CHAIN=4.
  - Exactly 4 handoffs, code 11.
  - Separately, abort asserted during PRESENT: the handoff and write-back still complete, then code 11.
- reset_n low during WB stall.
  - All outputs 0 immediately.
  - A subsequent start works normally.
